// File: rtl/delay_pipe_pkg.sv
// rtl/delay_pipe_pkg.sv - shared limits and helpers for the delay pipe
package delay_pipe_pkg;

    // Legal range for the number of register stages.
    localparam int DP_DEPTH_MIN = 1;
    localparam int DP_DEPTH_MAX = 16;

    // Bits needed to count 0..depth valid stages inclusive.
    function automatic int dp_occ_w(input int depth);
        return $clog2(depth + 1);
    endfunction

endpackage

// File: rtl/delay_pipe_if.sv
// rtl/delay_pipe_if.sv - valid/ready stream bundle for the delay pipe
//
// Signals:
//   in_valid/in_data/in_ready    upstream beat handshake
//   out_valid/out_data/out_ready downstream beat handshake
// Modports:
//   master - the environment driving the pipe (upstream source + downstream sink)
//   slave  - the delay pipe itself
interface delay_pipe_if #(
    parameter int WIDTH = 8
) ();
    logic             in_valid;
    logic [WIDTH-1:0] in_data;
    logic             in_ready;
    logic             out_valid;
    logic [WIDTH-1:0] out_data;
    logic             out_ready;

    modport master (
        output in_valid,
        output in_data,
        input  in_ready,
        input  out_valid,
        input  out_data,
        output out_ready
    );

    modport slave (
        input  in_valid,
        input  in_data,
        output in_ready,
        output out_valid,
        output out_data,
        input  out_ready
    );
endinterface

// File: rtl/delay_pipe_stage.sv
// rtl/delay_pipe_stage.sv - one valid/data register stage with ready chaining
//
// Ports:
//   clk, rst_n    clock, asynchronous active-low reset
//   flush_i       clear the valid at the next edge, data untouched
//   up_valid_i    valid from the previous stage (or the pipe input)
//   up_data_i     data from the previous stage (or the pipe input)
//   dn_rdy_i      ready from the next stage (or the pipe output)
//   rdy_o         this stage can take a beat: empty, or its beat is leaving
//   v_o, d_o      registered valid and data of this stage
module delay_pipe_stage #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             flush_i,
    input  logic             up_valid_i,
    input  logic [WIDTH-1:0] up_data_i,
    input  logic             dn_rdy_i,
    output logic             rdy_o,
    output logic             v_o,
    output logic [WIDTH-1:0] d_o
);

    logic             v_q, v_d;
    logic [WIDTH-1:0] d_q, d_d;

    // An empty stage always accepts, which is what lets bubbles collapse
    // while the output is stalled.
    assign rdy_o = !v_q || dn_rdy_i;

    always_comb begin
        v_d = v_q;
        d_d = d_q;
        if (flush_i) begin
            // Flush drops every beat, including one arriving this cycle;
            // data registers are left as they are.
            v_d = 1'b0;
        end else if (rdy_o) begin
            v_d = up_valid_i;
            if (up_valid_i) begin
                d_d = up_data_i;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            v_q <= 1'b0;
            d_q <= '0;
        end else begin
            v_q <= v_d;
            d_q <= d_d;
        end
    end

    assign v_o = v_q;
    assign d_o = d_q;

endmodule

// File: rtl/delay_pipe.sv
// rtl/delay_pipe.sv - DEPTH-stage valid/ready register pipe with bubble collapse
//
// Optional feature macro: DELAY_PIPE_OCC_EN (adds the occupancy port/counter).
//
// Ports:
//   clk        rising-edge clock
//   rst_n      asynchronous active-low reset (release synchronised outside)
//   flush      synchronous clear of all stage valids
//   bus        delay_pipe_if.slave: in_valid/in_data/in_ready upstream,
//              out_valid/out_data/out_ready downstream
//   occupancy  number of valid stages (only with DELAY_PIPE_OCC_EN)
module delay_pipe
    import delay_pipe_pkg::*;
#(
    parameter int WIDTH = 8,
    parameter int DEPTH = 2
) (
    input  logic                         clk,
    input  logic                         rst_n,
    input  logic                         flush,
    delay_pipe_if.slave                  bus
`ifdef DELAY_PIPE_OCC_EN
    ,
    output logic [dp_occ_w(DEPTH)-1:0]   occupancy
`endif
);

    if (DEPTH < DP_DEPTH_MIN || DEPTH > DP_DEPTH_MAX) begin : g_depth_illegal
        $error("delay_pipe: DEPTH out of range");
    end

    logic             v     [DEPTH];
    logic [WIDTH-1:0] d     [DEPTH];
    logic             up_v  [DEPTH];
    logic [WIDTH-1:0] up_d  [DEPTH];
    logic             rdy   [DEPTH+1];

    // The ready chain runs from the output back to the input.
    assign rdy[DEPTH]   = bus.out_ready;
    assign bus.in_ready = rdy[0];

    for (genvar i = 0; i < DEPTH; i++) begin : g_stage
        if (i == 0) begin : g_head
            assign up_v[i] = bus.in_valid;
            assign up_d[i] = bus.in_data;
        end else begin : g_body
            assign up_v[i] = v[i-1];
            assign up_d[i] = d[i-1];
        end

        delay_pipe_stage #(
            .WIDTH (WIDTH)
        ) u_stage (
            .clk        (clk),
            .rst_n      (rst_n),
            .flush_i    (flush),
            .up_valid_i (up_v[i]),
            .up_data_i  (up_d[i]),
            .dn_rdy_i   (rdy[i+1]),
            .rdy_o      (rdy[i]),
            .v_o        (v[i]),
            .d_o        (d[i])
        );
    end

    assign bus.out_valid = v[DEPTH-1];
    assign bus.out_data  = d[DEPTH-1];

`ifdef DELAY_PIPE_OCC_EN
    localparam int OCC_W = dp_occ_w(DEPTH);

    logic             in_xfer;
    logic             out_xfer;
    logic [OCC_W-1:0] occ_q, occ_d;

    assign in_xfer  = bus.in_valid  && rdy[0];
    assign out_xfer = v[DEPTH-1]    && bus.out_ready;

    always_comb begin
        occ_d = occ_q;
        if (flush) begin
            occ_d = '0;
        end else if (in_xfer && !out_xfer) begin
            // Saturate rather than wrap; the ready chain already keeps
            // the count within 0..DEPTH.
            if (occ_q != OCC_W'(DEPTH)) begin
                occ_d = occ_q + 1'b1;
            end
        end else if (out_xfer && !in_xfer) begin
            if (occ_q != '0) begin
                occ_d = occ_q - 1'b1;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            occ_q <= '0;
        end else begin
            occ_q <= occ_d;
        end
    end

    assign occupancy = occ_q;
`endif

endmodule

// File: doc/delay_pipe.md
DELAY_PIPE -- requirements
Module: delay_pipe

Interface
REQ-001 The block SHALL have parameter WIDTH, default 8, giving the data bits per beat.
REQ-002 The block SHALL have parameter DEPTH, default 2 (legal 1..16), giving the number of register stages.
REQ-003 The block SHALL have port clk, input, 1 bit: clock, rising-edge active.
REQ-004 The block SHALL have port rst_n, input, 1 bit: reset, asynchronous, active-low.
REQ-005 The block SHALL have port flush, input, 1 bit: synchronous clear of all stage valids.
REQ-006 The block SHALL have port in_valid, input, 1 bit: upstream beat present.
REQ-007 The block SHALL have port in_data, input, WIDTH bits: upstream beat payload.
REQ-008 The block SHALL have port in_ready, output, 1 bit: the block accepts a beat this cycle.
REQ-009 The block SHALL have port out_valid, output, 1 bit: the last stage holds a beat.
REQ-010 The block SHALL have port out_data, output, WIDTH bits: the last-stage payload.
REQ-011 The block SHALL have port out_ready, input, 1 bit: downstream accepts.
REQ-012 The block SHALL have port occupancy, output, $clog2(DEPTH+1) bits: the number of valid stages (present only per REQ-027).

Function
REQ-013 Stage i (0..DEPTH-1) SHALL hold registers v[i] and d[i]; stage 0 is fed by in_*; out_valid=v[DEPTH-1] and out_data=d[DEPTH-1].
REQ-014 Per-stage ready SHALL be combinational: rdy[DEPTH]=out_ready; rdy[i]=!v[i] || rdy[i+1]; in_ready=rdy[0].
REQ-015 When rdy[i]=1, stage i SHALL load v[i] from the upstream valid; d[i] SHALL load the upstream data only if the upstream valid=1, and SHALL hold otherwise.
REQ-016 When rdy[i]=0, stage i SHALL hold both v[i] and d[i] (stall); a held beat SHALL never be overwritten or dropped.
REQ-017 Bubbles SHALL collapse: an empty stage accepts even while downstream is stalled, so up to DEPTH beats are buffered under out_ready=0.
REQ-018 With out_ready held at 1, latency SHALL be exactly DEPTH cycles from an accepted in_valid to out_valid, and throughput SHALL be 1 beat/cycle.
REQ-019 A transfer SHALL occur at the input when in_valid && in_ready and at the output when out_valid && out_ready, both on the same clk edge.
REQ-020 Full pipeline (all v=1) with out_ready=1 SHALL accept a new beat in the same cycle (in_ready=1); with out_ready=0, in_ready SHALL be 0.
REQ-021 flush=1 SHALL clear every v[i] at the next edge, SHALL override any same-cycle input acceptance (the beat is discarded), and SHALL leave d[i] unchanged.
REQ-022 During flush, in_ready SHALL still follow REQ-014, and the upstream SHALL treat the beat as consumed.
REQ-023 out_data SHALL be stable while out_valid=1 and out_ready=0.

Reset
REQ-024 Assertion of rst_n low SHALL clear all v[i] to 0 and all d[i] to 0 asynchronously; out_valid=0, out_data=0, and occupancy=0 during reset.
REQ-025 A reset asserted mid-stream SHALL discard all buffered beats; after release, the first accepted beat SHALL appear after DEPTH cycles.
REQ-026 Deassertion of reset SHALL be synchronised externally; the block SHALL add no reset synchroniser.

Configuration
REQ-027 When macro DELAY_PIPE_OCC_EN is defined, the occupancy port and its registered counter SHALL exist: +1 on input transfer only, -1 on output transfer only, unchanged on both or neither, forced to 0 on flush or reset, range 0..DEPTH, no wrap.
REQ-028 When DELAY_PIPE_OCC_EN is undefined, the occupancy port and counter SHALL be absent, with no other behavioural change.

Structure
REQ-029 Package delay_pipe_pkg SHALL hold the DEPTH limits (DP_DEPTH_MIN=1, DP_DEPTH_MAX=16) and the occupancy width function.
REQ-030 A single-stage sub-module delay_pipe_stage (v/d registers plus the rdy equation) SHALL be instantiated DEPTH times in a generate loop.

Verification (WIDTH=8, DEPTH=2, DELAY_PIPE_OCC_EN defined)
REQ-031 Streaming: in_data 0x10,0x11,0x12 on consecutive cycles with out_ready=1 -> out_data 0x10,0x11,0x12 on cycles 2,3,4 and in_ready constantly 1.
REQ-032 Stall fill: out_ready=0, push 0xA1,0xA2 -> in_ready=0 after the second accept, occupancy=2, and out_data holds 0xA1; raise out_ready -> 0xA1 then 0xA2 out with no loss or duplication.
REQ-033 Bubble collapse: push 0x55, idle one cycle, push 0x66 with out_ready=0 -> both beats buffered and occupancy=2.
REQ-034 Full pass-through: pipeline full with out_ready=1 and in_valid=1 (0x77) -> same-cycle input and output transfers, and occupancy stays 2.
REQ-035 Flush with simultaneous push of 0x99 -> next cycle all v=0, occupancy=0, and 0x99 never appears at the output.
REQ-036 Reset mid-stream with 2 beats held -> out_valid=0 immediately, out_data=0x00, occupancy=0, and the next beat emerges 2 cycles after acceptance.
